// File: rtl/aes_encrypt128_dut.sv
// AES-128 encryption core with a fully unrolled outer-round pipeline.
// Stage 0 does the initial AddRoundKey; stages 1..10 each do one round with the
// round key expanded on the fly and carried alongside the state.
// Accepts one plaintext/key pair per clock; ciphertext appears 11 edges later.
//
// Ports:
//   clk   - system clock, rising-edge active
//   reset - asynchronous active-high reset; clears every stage
//   data  - 128-bit plaintext, byte 0 in [127:120], column-major state
//   key   - 128-bit cipher key, same byte ordering
//   out   - 128-bit ciphertext from the final stage (registered)
//   done  - high when out holds a valid ciphertext (registered)
module aes_encrypt128_dut (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] data,
  input  logic [127:0] key,
  output logic [127:0] out,
  output logic         done
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box computed as the GF(2^8) inverse (x^254, which maps 0 to 0) followed
  // by the affine transform, instead of a 256-entry table.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x3, x7, x15, x31, x63, x127, inv;
    x3   = gf_mul(gf_mul(x, x), x);
    x7   = gf_mul(gf_mul(x3, x3), x);
    x15  = gf_mul(gf_mul(x7, x7), x);
    x31  = gf_mul(gf_mul(x15, x15), x);
    x63  = gf_mul(gf_mul(x31, x31), x);
    x127 = gf_mul(gf_mul(x63, x63), x);
    inv  = gf_mul(x127, x127);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input int unsigned r);
    case (r)
      1:       return 8'h01;
      2:       return 8'h02;
      3:       return 8'h04;
      4:       return 8'h08;
      5:       return 8'h10;
      6:       return 8'h20;
      7:       return 8'h40;
      8:       return 8'h80;
      9:       return 8'h1b;
      10:      return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w3, t, n0, n1, n2, n3;
    w3 = k[31:0];
    // SubWord(RotWord(w3)): rotate left by one byte, then substitute
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] k,
                                            input logic last);
    logic [15:0][7:0] sb, sr, mc;
    logic [7:0]       a0, a1, a2, a3;
    logic [127:0]     res;
    for (int n = 0; n < 16; n++) sb[n] = sbox(s[127-8*n -: 8]);
    // Index n = row + 4*col; row r rotates left by r columns.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) sr[r+4*c] = sb[r+4*((c+r)%4)];
    end
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c+1];
      a2 = sr[4*c+2];
      a3 = sr[4*c+3];
      mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    res = '0;
    for (int n = 0; n < 16; n++) res[127-8*n -: 8] = last ? sr[n] : mc[n];
    return res ^ k;
  endfunction

  logic [10:0][127:0] s_q, s_d;
  logic [10:0][127:0] k_d;
  // The final-stage key only feeds its own AddRoundKey, so only keys 0..9 are stored.
  logic [9:0][127:0]  k_q;
  logic [10:0]        v_q;

  always_comb begin
    s_d    = '0;
    k_d    = '0;
    s_d[0] = data ^ key;
    k_d[0] = key;
    for (int i = 1; i <= 10; i++) begin
      k_d[i] = key_expand(k_q[i-1], rcon(i));
      s_d[i] = round_fn(s_q[i-1], k_d[i], i == 10);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q <= '0;
      k_q <= '0;
      v_q <= '0;
    end else begin
      s_q <= s_d;
      k_q <= k_d[9:0];
      v_q <= {v_q[9:0], 1'b1};
    end
  end

  assign out  = s_q[10];
  assign done = v_q[10];

endmodule

// File: tb/tb_aes_encrypt128_dut.sv
module tb_aes_encrypt128_dut;

  logic         clk;
  logic         reset;
  logic [127:0] data;
  logic [127:0] key;
  logic [127:0] out;
  logic         done;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [127:0] C1P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] BP  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] BK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] BC  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] ZC  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes_encrypt128_dut dut (
    .clk  (clk),
    .reset(reset),
    .data (data),
    .key  (key),
    .out  (out),
    .done (done)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #5;
    n_cmp++;
    if (out !== 128'h0) begin
      n_err++;
      $display("FAIL reset_out: got %h want %h", out, 128'h0);
    end
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_done: got %b want 0", done);
    end
  endtask

  task automatic test_reset_toggle();
    logic [127:0] pat [3];
    pat[0] = C1P;
    pat[1] = BP;
    pat[2] = 128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      data = pat[i];
      key  = ~pat[i];
      tick();
      n_cmp++;
      if (out !== 128'h0 || done !== 1'b0) begin
        n_err++;
        $display("FAIL reset_toggle[%0d]: got out=%h done=%b want out=0 done=0", i, out, done);
      end
    end
  endtask

  task automatic test_fips_c1();
    logic [127:0] first;
    while ($time < 100) @(negedge clk);
    data  = C1P;
    key   = C1K;
    reset = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      tick();
      n_cmp++;
      if (done !== (i == 11)) begin
        n_err++;
        $display("FAIL c1_done_edge%0d: got %b want %b", i, done, i == 11);
      end
    end
    n_cmp++;
    if (out !== C1C) begin
      n_err++;
      $display("FAIL c1_out: got %h want %h", out, C1C);
    end
    first = out;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (out !== C1C || done !== 1'b1) begin
        n_err++;
        $display("FAIL c1_hold[%0d]: got out=%h done=%b want out=%h done=1", i, out, done, C1C);
      end
    end
  endtask

  task automatic test_vector(input string name, input logic [127:0] p, input logic [127:0] k,
                             input logic [127:0] prev_c, input logic [127:0] exp_c);
    @(negedge clk);
    data = p;
    key  = k;
    for (int i = 1; i <= 11; i++) begin
      tick();
      if (i == 10) begin
        n_cmp++;
        if (out !== prev_c) begin
          n_err++;
          $display("FAIL %s_edge10_old: got %h want %h", name, out, prev_c);
        end
      end
    end
    n_cmp++;
    if (out !== exp_c || done !== 1'b1) begin
      n_err++;
      $display("FAIL %s_out: got out=%h done=%b want out=%h done=1", name, out, done, exp_c);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] exp [15];
    @(negedge clk);
    data = BP;
    key  = BK;
    for (int i = 0; i < 11; i++) tick();
    @(negedge clk);
    data = C1P;
    key  = C1K;
    tick();
    @(negedge clk);
    data = BP;
    key  = BK;
    tick();
    @(negedge clk);
    data = 128'h0;
    key  = 128'h0;
    tick();
    exp[10] = BC;
    exp[11] = C1C;
    exp[12] = BC;
    exp[13] = ZC;
    exp[14] = ZC;
    for (int e = 4; e <= 14; e++) begin
      tick();
      if (e >= 10) begin
        n_cmp++;
        if (out !== exp[e] || done !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_edge%0d: got out=%h done=%b want out=%h done=1",
                   e, out, done, exp[e]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    // Full pipeline: reset must clear outputs before any further clock edge.
    @(posedge clk);
    #5;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (out !== 128'h0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL mid_async_full: got out=%h done=%b want out=0 done=0", out, done);
    end
    @(negedge clk);
    data  = C1P;
    key   = C1K;
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_cmp++;
      if (done !== 1'b0) begin
        n_err++;
        $display("FAIL mid_fill_edge%0d: got done=%b want 0", i, done);
      end
    end
    #4;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (out !== 128'h0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL mid_async_partial: got out=%h done=%b want out=0 done=0", out, done);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      tick();
      n_cmp++;
      if (done !== (i == 11)) begin
        n_err++;
        $display("FAIL mid_refill_edge%0d: got %b want %b", i, done, i == 11);
      end
    end
    n_cmp++;
    if (out !== C1C) begin
      n_err++;
      $display("FAIL mid_refill_out: got %h want %h", out, C1C);
    end
  endtask

  initial begin
    reset = 1'b1;
    data  = C1P;
    key   = C1K;
    test_reset();
    test_reset_toggle();
    test_fips_c1();
    test_vector("fips_b", BP, BK, C1C, BC);
    test_vector("zero", 128'h0, 128'h0, BC, ZC);
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
